// File: rtl/s_arb_pkg.sv
// Shared types and constants for the S-memory arbiter.
package s_arb_pkg;

  // Phase encoding, also exported on the phase port.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    KSA  = 3'd2,
    PRGA = 3'd3,
    DONE = 3'd4
  } phase_t;

  // Requester indices into the packed request/grant/rvalid vectors.
  localparam int unsigned REQ_INIT = 0;
  localparam int unsigned REQ_KSA  = 1;
  localparam int unsigned REQ_PRGA = 2;
  localparam int unsigned NUM_REQ  = 3;

  // One-hot owner vector for a phase; all zeros when nobody owns the memory.
  function automatic logic [NUM_REQ-1:0] owner_of(phase_t ph);
    logic [NUM_REQ-1:0] own;
    own = '0;
    case (ph)
      INIT:    own[REQ_INIT] = 1'b1;
      KSA:     own[REQ_KSA]  = 1'b1;
      PRGA:    own[REQ_PRGA] = 1'b1;
      default: own = '0;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/s_arb_phase_fsm.sv
// Phase sequencer: IDLE -> INIT -> KSA -> PRGA -> DONE, restartable from IDLE or DONE.
module s_arb_phase_fsm
  import s_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_REQ-1:0]  done,
  output logic [2:0]          phase,
  output logic                busy,
  output logic                all_done,
  output logic                start_ok
);

  phase_t state_q, state_d;

  // Start is only honoured when no phase is in progress.
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign phase    = state_q;

  // Next-state: only the current owner's done pulse advances the phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = INIT;
      INIT:    if (done[REQ_INIT]) state_d = KSA;
      KSA:     if (done[REQ_KSA]) state_d = PRGA;
      PRGA:    if (done[REQ_PRGA]) state_d = DONE;
      DONE:    if (start_ok) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  // State plus status flags registered together so the flags track the registered state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      busy     <= 1'b0;
      all_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d == INIT) || (state_d == KSA) || (state_d == PRGA);
      all_done <= (state_d == DONE);
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// Single-port S-memory arbiter shared by the init, ksa and prga engines.
// The current phase decides the sole owner; grants are combinational and
// read data comes back one cycle later on the shared rdata bus.
module s_mem_arbiter
  import s_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,

  input  logic              init_req,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  input  logic              init_wren,
  input  logic              init_done,
  output logic              init_grant,
  output logic              init_rvalid,

  input  logic              ksa_req,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wdata,
  input  logic              ksa_wren,
  input  logic              ksa_done,
  output logic              ksa_grant,
  output logic              ksa_rvalid,

  input  logic              prga_req,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wdata,
  input  logic              prga_wren,
  input  logic              prga_done,
  output logic              prga_grant,
  output logic              prga_rvalid,

  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,

  output logic [2:0]        phase,
  output logic              busy,
  output logic              all_done,
  output logic              err,
  output logic [CNT_W-1:0]  access_count
);

  logic [NUM_REQ-1:0] req_v, wren_v, done_v;
  logic [NUM_REQ-1:0] owner, grant;
  logic [NUM_REQ-1:0] rvalid_q;
  logic               grant_any;
  logic               violation;
  logic               start_ok;
  logic [ADDR_W-1:0]  sel_addr, addr_q;
  logic [DATA_W-1:0]  sel_data, data_q;
  logic               sel_wren;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  assign req_v  = {prga_req, ksa_req, init_req};
  assign wren_v = {prga_wren, ksa_wren, init_wren};
  assign done_v = {prga_done, ksa_done, init_done};

  s_arb_phase_fsm u_phase_fsm (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done_v),
    .phase    (phase),
    .busy     (busy),
    .all_done (all_done),
    .start_ok (start_ok)
  );

  assign owner     = owner_of(phase_t'(phase));
  assign grant     = req_v & owner;
  assign grant_any = |grant;

  // Any request or done from a requester that does not own the memory is a protocol error.
  assign violation = |(req_v & ~owner) | |(done_v & ~owner);

  assign init_grant = grant[REQ_INIT];
  assign ksa_grant  = grant[REQ_KSA];
  assign prga_grant = grant[REQ_PRGA];

  // Select the owner's access fields; only consumed when a grant is present.
  always_comb begin
    sel_addr = init_addr;
    sel_data = init_wdata;
    sel_wren = init_wren;
    case (phase_t'(phase))
      KSA: begin
        sel_addr = ksa_addr;
        sel_data = ksa_wdata;
        sel_wren = ksa_wren;
      end
      PRGA: begin
        sel_addr = prga_addr;
        sel_data = prga_wdata;
        sel_wren = prga_wren;
      end
      default: ;
    endcase
  end

  // Memory port: live owner fields on a grant, otherwise the last driven address/data.
  assign mem_addr = grant_any ? sel_addr : addr_q;
  assign mem_data = grant_any ? sel_data : data_q;
  assign mem_wren = grant_any & sel_wren;
  assign rdata    = mem_q;

  // Hold the last driven address/data so the memory port is stable between grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (grant_any) begin
      addr_q <= sel_addr;
      data_q <= sel_data;
    end
  end

  // Per-requester read-valid, so a read issued just before a phase change still
  // returns to the requester that issued it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= grant & ~wren_v;
    end
  end

  assign init_rvalid = rvalid_q[REQ_INIT];
  assign ksa_rvalid  = rvalid_q[REQ_KSA];
  assign prga_rvalid = rvalid_q[REQ_PRGA];

  // Sticky error flag; a violation in the same cycle as an accepted start still sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= violation | (err_q & ~start_ok);
    end
  end

  assign err = err_q;

  // Saturating count of granted accesses since the last accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
    end else if (grant_any && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign access_count = cnt_q;

endmodule
